// File: rtl/projeto_200917_qsys_gpio_pio.sv
// projeto_200917_qsys_gpio_pio: Avalon-MM GPIO port with a per-bit direction
// register, atomic set/clear writes and a two-flop input synchroniser.
// Optional rising-edge capture, interrupt mask and registered irq are built
// only when the macro GPIO_EDGE_IRQ_EN is defined; otherwise addresses 2/3
// read 0 and irq is tied low.
module projeto_200917_qsys_gpio_pio #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] direction;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] rd;

  // Bits of writedata above WIDTH are intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, writedata};

  assign wr    = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];

  // Output data, direction and the input synchroniser.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= RESET_VALUE;
      direction <= '0;
      sync1     <= '0;
      sync2     <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      if (wr) begin
        case (address)
          ADDR_DATA:     data_out  <= wdata;
          ADDR_DIR:      direction <= wdata;
          ADDR_OUTSET:   data_out  <= data_out | wdata;
          ADDR_OUTCLEAR: data_out  <= data_out & ~wdata;
          default:       ;
        endcase
      end
    end
  end

  assign out_port = data_out;
  assign oe_port  = direction;

`ifdef GPIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [1:0]       arm_cnt;
  logic             armed;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] clear_mask;
  logic             irq_q;

  assign armed      = (arm_cnt == 2'd3);
  assign edge_set   = armed ? (sync2 & ~prev) : '0;
  assign clear_mask = (wr && address == ADDR_EDGECAP) ? wdata : '0;

  // Edge detection, capture (set beats clear), arm counter and irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev         <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      arm_cnt      <= 2'd0;
      irq_q        <= 1'b0;
    end else begin
      prev <= sync2;
      if (!armed) begin
        arm_cnt <= arm_cnt + 2'd1;
      end
      if (wr && address == ADDR_IRQMASK) begin
        irq_mask <= wdata;
      end
      edge_capture <= (edge_capture & ~clear_mask) | edge_set;
      irq_q        <= |(edge_capture & irq_mask);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Combinational read mux; unmapped and write-only addresses read 0.
  always_comb begin
    rd = '0;
    case (address)
      ADDR_DATA:    rd = (data_out & direction) | (sync2 & ~direction);
      ADDR_DIR:     rd = direction;
`ifdef GPIO_EDGE_IRQ_EN
      ADDR_IRQMASK: rd = irq_mask;
      ADDR_EDGECAP: rd = edge_capture;
`endif
      default:      rd = '0;
    endcase
  end

  assign readdata = 32'(rd);

endmodule

// File: tb/tb_projeto_200917_qsys_gpio_pio.sv
// Self-checking bench for projeto_200917_qsys_gpio_pio (WIDTH=8, RESET_VALUE=8'hA5).
module tb_projeto_200917_qsys_gpio_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic [7:0]  oe_port;
  logic        irq;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  projeto_200917_qsys_gpio_pio #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe_port    (oe_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expectation pushed with the stimulus, popped against DUT output.
  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cycle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
    push_exp(tag, exp);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #2;
    pop_cmp(readdata);
    chipselect = 1'b0;
  endtask

  task automatic pin_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    push_exp(tag, exp);
    pop_cmp(obs);
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 8'h3C;
    cycle(3);
    pin_check("rst_out_port", 32'(out_port), 32'h0000_00A5);
    pin_check("rst_oe_port",  32'(oe_port),  32'h0);
    pin_check("rst_irq",      32'(irq),      32'h0);
    reset = 1'b0;
    cycle(2);
    bus_read("rst_rd_data", 3'd0, 32'h0000_003C);
    bus_read("rst_rd_dir",  3'd1, 32'h0);

    // Output path: DATA, OUTSET, OUTCLEAR.
    bus_write(3'd1, 32'h0000_00FF);
    pin_check("oe_ff", 32'(oe_port), 32'h0000_00FF);
    bus_write(3'd0, 32'hFFFF_FF0F);
    pin_check("out_0f", 32'(out_port), 32'h0000_000F);
    bus_write(3'd4, 32'h0000_0030);
    pin_check("out_set", 32'(out_port), 32'h0000_003F);
    bus_write(3'd5, 32'h0000_0003);
    pin_check("out_clr", 32'(out_port), 32'h0000_003C);
    bus_read("rd_data_3c", 3'd0, 32'h0000_003C);
    bus_read("rd_outset",  3'd4, 32'h0);
    bus_read("rd_outclr",  3'd5, 32'h0);

    // Write without chipselect is ignored.
    address = 3'd0; writedata = 32'h55; write_n = 1'b0; chipselect = 1'b0;
    cycle();
    write_n = 1'b1;
    pin_check("no_cs_write", 32'(out_port), 32'h0000_003C);

    // Mixed direction readback.
    bus_write(3'd1, 32'h0000_000F);
    bus_write(3'd0, 32'h0000_00AA);
    in_port = 8'h50;
    cycle(3);
    bus_read("rd_mixed", 3'd0, 32'h0000_005A);

    // Unmapped addresses.
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read("rd_a6", 3'd6, 32'h0);
    bus_read("rd_a7", 3'd7, 32'h0);
    pin_check("a67_no_effect", 32'(out_port), 32'h0000_00AA);

`ifdef GPIO_EDGE_IRQ_EN
    in_port = 8'h00;
    cycle(4);
    bus_write(3'd2, 32'h0000_0004);
    bus_read("rd_mask", 3'd2, 32'h0000_0004);
    in_port = 8'h04;
    cycle();                                 // edge k
    bus_read("cap_k1", 3'd3, 32'h0);
    cycle();                                 // edge k+1
    bus_read("cap_k2", 3'd3, 32'h0);
    cycle();                                 // edge k+2
    bus_read("cap_k3", 3'd3, 32'h0000_0004);
    pin_check("irq_k2", 32'(irq), 32'h0);
    cycle();                                 // edge k+3
    pin_check("irq_k3", 32'(irq), 32'h1);
    // Clear deasserts irq one cycle later.
    bus_write(3'd3, 32'h0000_0004);
    bus_read("cap_cleared", 3'd3, 32'h0);
    pin_check("irq_hold", 32'(irq), 32'h1);
    cycle();
    pin_check("irq_clr", 32'(irq), 32'h0);
    // Capture again, then clear on the same cycle as a new rising edge.
    in_port = 8'h00;
    cycle(4);
    in_port = 8'h04;
    cycle(4);
    bus_read("cap_again", 3'd3, 32'h0000_0004);
    in_port = 8'h00;
    cycle(4);
    in_port = 8'h04;
    cycle(2);                                // edge k, k+1
    bus_write(3'd3, 32'h0000_0004);          // edge k+2: set and clear collide
    bus_read("set_wins", 3'd3, 32'h0000_0004);
    cycle(2);
    pin_check("irq_set_wins", 32'(irq), 32'h1);
    // Removing the mask deasserts irq one cycle later.
    bus_write(3'd2, 32'h0);
    pin_check("irq_mask_hold", 32'(irq), 32'h1);
    cycle();
    pin_check("irq_mask_off", 32'(irq), 32'h0);

    // Pins already high through reset must not capture.
    in_port = 8'hFF;
    reset   = 1'b1;
    cycle(2);
    pin_check("rst2_out_port", 32'(out_port), 32'h0000_00A5);
    reset = 1'b0;
    cycle(6);
    bus_read("rst2_cap", 3'd3, 32'h0);
    pin_check("rst2_irq", 32'(irq), 32'h0);
    in_port = 8'hFE;
    cycle(4);
    in_port = 8'hFF;
    cycle(4);
    bus_read("cap_bit0", 3'd3, 32'h0000_0001);
`else
    bus_write(3'd2, 32'hFFFF_FFFF);
    bus_write(3'd3, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      in_port = (i % 2 == 0) ? 8'hFF : 8'h00;
      cycle(4);
      pin_check("irq_off", 32'(irq), 32'h0);
    end
    bus_read("rd_a2", 3'd2, 32'h0);
    bus_read("rd_a3", 3'd3, 32'h0);
`endif

    check_eq("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
